// File: rtl/rv_mult_seq_if.sv
// Request/response bundle between the execute stage and the multiply sequencer.
//   req_valid/req_ready : request handshake, carries req_fun/req_rs1/req_rs2
//   rsp_valid/rsp_ready : response handshake, carries rsp_rd
//   kill                : abort whatever operation is in flight
// master = execute-stage side, slave = sequencer side.
interface rv_mult_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fun;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        kill;

  modport master (
    output req_valid, req_fun, req_rs1, req_rs2, rsp_ready, kill,
    input  req_ready, rsp_valid, rsp_rd
  );

  modport slave (
    input  req_valid, req_fun, req_rs1, req_rs2, rsp_ready, kill,
    output req_ready, rsp_valid, rsp_rd
  );
endinterface

// File: rtl/rv_mult_seq.sv
// Iterative RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU) built around one
// shared, registered 18x18 signed multiplier slice. The 34-bit extended
// operands are split into 17-bit halves and the partial products ll, lh, hl
// (and hh for high-half ops) are issued one per cycle and accumulated into a
// 64-bit sum one cycle later.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   bus            : request/response handshake plus kill (slave side)
//   mul_x_o/mul_y_o: signed operands for the external multiplier slice
//   mul_ce_o       : multiplier register enable
//   mul_q_i        : registered product, valid the cycle after issue
module rv_mult_seq #(
  parameter int unsigned ACC_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  rv_mult_seq_if.slave       bus,
  output logic [17:0]        mul_x_o,
  output logic [17:0]        mul_y_o,
  output logic               mul_ce_o,
  input  logic [35:0]        mul_q_i
);

  localparam int unsigned OP_W    = 32;
  localparam int unsigned EXT_W   = 34;
  localparam int unsigned SLICE_W = 18;
  localparam int unsigned PROD_W  = 36;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] FUN_MUL    = 2'b00;
  localparam logic [1:0] FUN_MULH   = 2'b01;
  localparam logic [1:0] FUN_MULHSU = 2'b10;

  // Low half is unsigned 17 bits; high half carries the sign of the 34-bit value.
  function automatic logic [SLICE_W-1:0] lo_of(input logic [EXT_W-1:0] e);
    return {1'b0, e[16:0]};
  endfunction

  function automatic logic [SLICE_W-1:0] hi_of(input logic [EXT_W-1:0] e);
    return {e[EXT_W-1], e[EXT_W-1:17]};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [1:0]         fun_q, fun_d;
  logic [EXT_W-1:0]   x_q, x_d;
  logic [EXT_W-1:0]   y_q, y_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]    rsp_rd_q, rsp_rd_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               mul_ce_q, mul_ce_d;
  logic [SLICE_W-1:0] mul_x_q, mul_x_d;
  logic [SLICE_W-1:0] mul_y_q, mul_y_d;

  logic [1:0]         last_k;
  logic [1:0]         prod_k;
  logic [5:0]         shamt;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   addend;
  logic               rs1_signed;
  logic               rs2_signed;

  // MUL skips hh: it only reaches bits 63:34, outside the returned low word.
  assign last_k = (fun_q == FUN_MUL) ? 2'd2 : 2'd3;

  // Product arriving now belongs to the previous issue slot (or the last one in DRAIN).
  assign prod_k = (state_q == ST_DRAIN) ? k_q : k_q - 2'd1;
  assign shamt  = (prod_k == 2'd0) ? 6'd0 : ((prod_k == 2'd3) ? 6'd34 : 6'd17);

  assign prod_ext = {{(ACC_W-PROD_W){mul_q_i[PROD_W-1]}}, mul_q_i};
  assign addend   = prod_ext << shamt;

  assign rs1_signed = (bus.req_fun == FUN_MULH) || (bus.req_fun == FUN_MULHSU);
  assign rs2_signed = (bus.req_fun == FUN_MULH);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    fun_d       = fun_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_d       = acc_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        // A kill in IDLE has no operation to abort but still blocks acceptance.
        if (bus.req_valid && !bus.kill) begin
          state_d = ST_ISSUE;
          k_d     = 2'd0;
          fun_d   = bus.req_fun;
          x_d     = {{2{rs1_signed & bus.req_rs1[OP_W-1]}}, bus.req_rs1};
          y_d     = {{2{rs2_signed & bus.req_rs2[OP_W-1]}}, bus.req_rs2};
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (k_q != 2'd0) begin
          acc_d = acc_q + addend;
        end
        if (k_q == last_k) begin
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        acc_d       = acc_q + addend;
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
        rsp_rd_d    = (fun_q == FUN_MUL) ? acc_d[OP_W-1:0] : acc_d[ACC_W-1:OP_W];
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything, including a response handshake.
    if (bus.kill && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end

    req_ready_d = (state_d == ST_IDLE);
    mul_ce_d    = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    mul_x_d     = '0;
    mul_y_d     = '0;
    if (state_d == ST_ISSUE) begin
      // k[1] selects the x half, k[0] the y half: ll, lh, hl, hh.
      mul_x_d = k_d[1] ? hi_of(x_d) : lo_of(x_d);
      mul_y_d = k_d[0] ? hi_of(y_d) : lo_of(y_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      fun_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      rsp_rd_q    <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      mul_ce_q    <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fun_q       <= fun_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      mul_ce_q    <= mul_ce_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign mul_x_o       = mul_x_q;
  assign mul_y_o       = mul_y_q;
  assign mul_ce_o      = mul_ce_q;

endmodule

// File: tb/tb_rv_mult_seq.sv
// Bench for rv_mult_seq: models the external registered 18x18 multiplier,
// runs directed cases and a randomized sequence against a plain 64-bit
// product reference.
module tb_rv_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] mul_x;
  logic [17:0] mul_y;
  logic        mul_ce;
  logic [35:0] mul_q;

  int checks = 0;
  int passes = 0;

  rv_mult_seq_if bus ();

  rv_mult_seq #(.ACC_W(64)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus),
    .mul_x_o  (mul_x),
    .mul_y_o  (mul_y),
    .mul_ce_o (mul_ce),
    .mul_q_i  (mul_q)
  );

  always #5 clk = ~clk;

  // External multiplier slice: signed 18x18, one register stage, clock-enabled.
  always @(posedge clk) begin
    if (mul_ce) mul_q <= 36'({{18{mul_x[17]}}, mul_x} * {{18{mul_y[17]}}, mul_y});
  end

  // Reference: architectural RV32M result from a full 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then wait (bounded) for rsp_valid.
  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int ce);
    bus.req_fun   = f;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    lat = 0;
    ce  = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      if (mul_ce === 1'b1) ce++;
      step();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int lat, ce, n;
    logic [31:0] exp;
    bit stable;
    exp = ref_mul(f, a, b);
    n   = (f == 2'b00) ? 3 : 4;
    bus.rsp_ready = 1'b0;
    launch(f, a, b, lat, ce);
    check({tag, "_latency"}, 64'(lat), 64'(n + 1));
    check({tag, "_ce_cycles"}, 64'(ce), 64'(n + 1));
    check({tag, "_result"}, 64'(bus.rsp_rd), 64'(exp));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rd !== exp || bus.req_ready !== 1'b0) stable = 1'b0;
      step();
    end
    if (hold > 0) check({tag, "_hold"}, 64'(stable), 64'd1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_release"}, {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);
  endtask

  initial begin
    int lat, ce;
    bit quiet;
    logic [1:0]  f;
    logic [31:0] a, b, exp;
    bit done, seen, k, r, vld;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_fun   = 2'b00;
    bus.req_rs1   = 32'h0;
    bus.req_rs2   = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.kill      = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_rsp_rd", 64'(bus.rsp_rd), 64'd0);
    check("reset_mul_ports", {27'd0, mul_ce, mul_x, mul_y}, 64'd0);

    do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
    do_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("backpressure", 2'b00, 32'hFFFF_FFFF, 32'd2, 10);

    // kill together with a request in IDLE accepts nothing
    bus.req_fun   = 2'b00;
    bus.req_rs1   = 32'd9;
    bus.req_rs2   = 32'd9;
    bus.req_valid = 1'b1;
    bus.kill      = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    check("kill_blocks_accept", {62'd0, bus.req_ready, mul_ce}, 64'b10);

    // kill at k=2 of a MULH
    bus.req_fun   = 2'b01;
    bus.req_rs1   = 32'h8000_0000;
    bus.req_rs2   = 32'h1234_5678;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_to_idle", {61'd0, bus.rsp_valid, bus.req_ready, mul_ce}, 64'b010);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
      step();
    end
    check("kill_no_rsp", 64'(quiet), 64'd1);
    do_op("after_kill", 2'b00, 32'd3, 32'd5, 0);

    // synchronous reset in DONE
    launch(2'b00, 32'd9, 32'd9, lat, ce);
    check("pre_reset_result", 64'(bus.rsp_rd), 64'd81);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("done_reset", {60'd0, bus.rsp_valid, bus.req_ready, mul_ce, |bus.rsp_rd}, 64'b0100);

    // reset pulse between edges must be ignored
    launch(2'b00, 32'd4, 32'd4, lat, ce);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("async_pulse_ignored", {31'd0, bus.rsp_valid, bus.rsp_rd}, {31'd0, 1'b1, 32'd16});
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("async_pulse_release", {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);

    // randomized operations with random backpressure and flushes
    for (int n = 0; n < 3000; n++) begin
      f   = 2'($urandom % 4);
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_mul(f, a, b);
      bus.kill      = 1'b0;
      bus.rsp_ready = 1'($urandom % 2);
      bus.req_fun   = f;
      bus.req_rs1   = a;
      bus.req_rs2   = b;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      done = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        if (bus.rsp_valid === 1'b1 && !seen) begin
          seen = 1'b1;
          check("rnd_result", 64'(bus.rsp_rd), 64'(exp));
          check("rnd_latency", 64'(c), (f == 2'b00) ? 64'd4 : 64'd5);
        end
        k   = ($urandom % 20) == 0;
        r   = 1'($urandom % 2);
        vld = bus.rsp_valid;
        bus.kill      = k;
        bus.rsp_ready = r;
        step();
        if (k) begin
          check("rnd_kill", {61'd0, bus.rsp_valid, bus.req_ready, mul_ce}, 64'b010);
          done = 1'b1;
        end else if (vld && r) begin
          check("rnd_release", {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);
          done = 1'b1;
        end
      end
      bus.kill      = 1'b0;
      bus.rsp_ready = 1'b0;
      if (!done) check("rnd_timeout", 64'd0, 64'd1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
